sad_search_sequencer: RTL

- Drives the instruction and index inputs of the VBSME SAD datapath, stepping through candidate search positions one per cycle.
- Collects each returned SAD value/index pair after the datapath latency and keeps the running minimum.
- Reports the best match with a one-cycle done pulse.
- Sits above the SAD datapath top level, between it and the testbench/host control.

---
 rtl/sad_search_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sad_search_sequencer.sv
// Sequences candidate search positions into the SAD datapath and tracks the minimum returned SAD.
// Latency: first issue one cycle after Start; Done NUM_POS+LATENCY cycles after the Start edge.
// Backpressure: none; positions issue one per cycle, and Start is ignored unless the block is idle.
module sad_search_sequencer #(
  parameter int          NUM_POS     = 64,
  parameter int          LATENCY     = 3,
  parameter logic [31:0] INVALID_SAD = 32'd9999
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] SADInstr,
  input  logic [31:0] SADValIn,
  input  logic [31:0] SADIndexIn,
  output logic [31:0] InstructionOut,
  output logic [31:0] index,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] BestSAD,
  output logic [31:0] BestIndex,
  output logic [15:0] ResultCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_POS = 16'(NUM_POS - 1);

  state_t               state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [LATENCY-1:0]   vpipe_q, vpipe_d;
  logic [31:0]          best_sad_q, best_sad_d;
  logic [31:0]          best_idx_q, best_idx_d;
  logic [15:0]          res_cnt_q, res_cnt_d;
  logic                 qual;

  // The pipe's top bit marks the cycle whose SADValIn/SADIndexIn belong to an issued position.
  assign qual = vpipe_q[LATENCY-1];

  // State register and datapath flops; reset can land at any time, even mid-search.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      cnt_q      <= '0;
      vpipe_q    <= '0;
      best_sad_q <= 32'hFFFF_FFFF;
      best_idx_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      vpipe_q    <= vpipe_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  // Next-state, issue counter, valid pipe and running-minimum update.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    res_cnt_d  = res_cnt_q;

    // Shift every cycle; a one enters only for cycles that issue a position.
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = (state_q == S_ISSUE);

    // Sentinel results are dropped outright; strict compare keeps the earliest index on ties.
    if (qual && (SADValIn != INVALID_SAD)) begin
      if (res_cnt_q != 16'hFFFF) begin
        res_cnt_d = res_cnt_q + 16'd1;
      end
      if (SADValIn < best_sad_q) begin
        best_sad_d = SADValIn;
        best_idx_d = SADIndexIn;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          instr_d    = SADInstr;
          best_sad_d = 32'hFFFF_FFFF;
          best_idx_d = '0;
          res_cnt_d  = '0;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The counter stops on the last position so index holds it through the drain.
        if (cnt_q == LAST_POS) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        // Leave once the final valid bit shifts out; its capture happens on this same edge.
        if (vpipe_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign InstructionOut = (state_q == S_ISSUE) ? instr_q : 32'd0;
  assign index          = {16'd0, cnt_q};
  assign Busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign Done           = (state_q == S_DONE);
  assign BestSAD        = best_sad_q;
  assign BestIndex      = best_idx_q;
  assign ResultCount    = res_cnt_q;

endmodule
